// File: rtl/z80fi_insn_capture_if.sv
// Purpose: groups the capture block's T-state inputs and its published retire record.
// Latency: none, this is wiring only.
// Backpressure: none; the retire record is a one-cycle strobe with outputs held until the next retire.
interface z80fi_insn_capture_if;
    // Per-T-state activity reported by the CPU core
    logic        insn_start;
    logic        mcycle_start;
    logic [2:0]  mcycle_type;
    logic        fetch_valid;
    logic [7:0]  fetch_byte;
    logic        insn_end;

    // Published record of the last retired instruction
    logic        z80fi_valid;
    logic [31:0] z80fi_insn;
    logic [2:0]  z80fi_insn_len;
    logic [17:0] z80fi_mcycle_types;
    logic [23:0] z80fi_tcycles;
    logic        capture_error;

    // Core side: drives activity, observes the record
    modport master (
        output insn_start,
        output mcycle_start,
        output mcycle_type,
        output fetch_valid,
        output fetch_byte,
        output insn_end,
        input  z80fi_valid,
        input  z80fi_insn,
        input  z80fi_insn_len,
        input  z80fi_mcycle_types,
        input  z80fi_tcycles,
        input  capture_error
    );

    // Capture side: observes activity, drives the record
    modport slave (
        input  insn_start,
        input  mcycle_start,
        input  mcycle_type,
        input  fetch_valid,
        input  fetch_byte,
        input  insn_end,
        output z80fi_valid,
        output z80fi_insn,
        output z80fi_insn_len,
        output z80fi_mcycle_types,
        output z80fi_tcycles,
        output capture_error
    );
endinterface

// File: rtl/z80fi_insn_capture.sv
// Purpose: records fetched bytes, machine-cycle types and per-cycle T-state counts of one Z80 instruction.
// Latency: the record is published on the clock edge that ends the insn_end T-state, so z80fi_valid is high the next cycle.
// Backpressure: none; the consumer must take the one-cycle z80fi_valid strobe, and outputs hold until the next retire.
module z80fi_insn_capture (
    input logic                 clk,
    input logic                 reset,
    z80fi_insn_capture_if.slave cap
);

    localparam logic [0:0] IDLE       = 1'b0;
    localparam logic [0:0] ACTIVE     = 1'b1;
    localparam logic [2:0] MAX_SLOTS  = 3'd6;
    localparam logic [2:0] MAX_BYTES  = 3'd4;
    localparam logic [3:0] TCOUNT_MAX = 4'hF;

    logic [0:0]  state;

    // Working buffers for the instruction being captured
    logic [31:0] w_insn;
    logic [2:0]  w_len;
    logic [17:0] w_types;
    logic [23:0] w_tc;
    logic [2:0]  w_nslots;   // slots opened so far, 1..6 while active
    logic        w_dead;     // a 7th machine cycle arrived; slot counts are frozen
    logic        w_err;

    // Working buffers after this T-state's updates
    logic [31:0] n_insn;
    logic [2:0]  n_len;
    logic [17:0] n_types;
    logic [23:0] n_tc;
    logic [2:0]  n_nslots;
    logic        n_dead;
    logic        n_err;

    logic        active;
    logic        start;
    logic        collide;
    logic        publish;
    logic [2:0]  open_slot;

    // Published record
    logic        pub_valid;
    logic [31:0] pub_insn;
    logic [2:0]  pub_len;
    logic [17:0] pub_types;
    logic [23:0] pub_tc;
    logic        pub_err;

    // Apply one T-state of activity to the working buffers
    always_comb begin
        active    = (state == ACTIVE);
        // insn_start together with insn_end while active finishes the old instruction
        // and is otherwise ignored, so only the other cases begin a new capture.
        start     = cap.insn_start && (!active || !cap.insn_end);
        collide   = active && cap.insn_start && cap.insn_end;
        publish   = active && cap.insn_end;
        open_slot = w_nslots - 3'd1;

        n_insn    = w_insn;
        n_len     = w_len;
        n_types   = w_types;
        n_tc      = w_tc;
        n_nslots  = w_nslots;
        n_dead    = w_dead;
        n_err     = w_err;

        if (start) begin
            // Abandoning an unfinished instruction marks the replacement as suspect.
            n_insn        = '0;
            n_len         = '0;
            n_types       = '0;
            n_tc          = '0;
            n_types[2:0]  = cap.mcycle_type;
            n_tc[3:0]     = 4'd1;
            n_nslots      = 3'd1;
            n_dead        = 1'b0;
            n_err         = active;
        end else if (active) begin
            if (cap.mcycle_start && !collide) begin
                if (w_nslots == MAX_SLOTS) begin
                    n_dead = 1'b1;
                    n_err  = 1'b1;
                end else begin
                    n_types[3*w_nslots +: 3] = cap.mcycle_type;
                    n_tc[4*w_nslots +: 4]    = 4'd1;
                    n_nslots                 = w_nslots + 3'd1;
                end
            end else if (!w_dead && (w_tc[4*open_slot +: 4] != TCOUNT_MAX)) begin
                n_tc[4*open_slot +: 4] = w_tc[4*open_slot +: 4] + 4'd1;
            end
            if (collide) begin
                n_err = 1'b1;
            end
        end

        // Fetches count on every captured T-state, including the first and last.
        if ((start || active) && cap.fetch_valid) begin
            if (n_len == MAX_BYTES) begin
                n_err = 1'b1;
            end else begin
                n_insn[8*n_len +: 8] = cap.fetch_byte;
                n_len                = n_len + 3'd1;
            end
        end
    end

    // Capture state and working buffers; reset abandons any partial capture
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            w_insn   <= '0;
            w_len    <= '0;
            w_types  <= '0;
            w_tc     <= '0;
            w_nslots <= '0;
            w_dead   <= 1'b0;
            w_err    <= 1'b0;
        end else begin
            if (publish) begin
                state <= IDLE;
            end else if (start) begin
                state <= ACTIVE;
            end
            w_insn   <= n_insn;
            w_len    <= n_len;
            w_types  <= n_types;
            w_tc     <= n_tc;
            w_nslots <= n_nslots;
            w_dead   <= n_dead;
            w_err    <= n_err;
        end
    end

    // Publish the completed record, including the final T-state's updates
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pub_valid <= 1'b0;
            pub_insn  <= '0;
            pub_len   <= '0;
            pub_types <= '0;
            pub_tc    <= '0;
            pub_err   <= 1'b0;
        end else begin
            pub_valid <= publish;
            if (publish) begin
                pub_insn  <= n_insn;
                pub_len   <= n_len;
                pub_types <= n_types;
                pub_tc    <= n_tc;
                pub_err   <= n_err;
            end
        end
    end

    assign cap.z80fi_valid        = pub_valid;
    assign cap.z80fi_insn         = pub_insn;
    assign cap.z80fi_insn_len     = pub_len;
    assign cap.z80fi_mcycle_types = pub_types;
    assign cap.z80fi_tcycles      = pub_tc;
    assign cap.capture_error      = pub_err;

endmodule

// File: doc/z80fi_insn_capture.md
Z80FI_INSN_CAPTURE -- requirements
Module: z80fi_insn_capture

Interface
REQ-001 SHALL have port: clk  in  1  sole clock; one clk edge = one T-state.
REQ-002 SHALL have port: reset  in  1  reset, asynchronous, active-high.
REQ-003 SHALL have port: insn_start  in  1  first T-state of an instruction's first M1; always accompanied by mcycle_start.
REQ-004 SHALL have port: mcycle_start  in  1  first T-state of a machine cycle.
REQ-005 SHALL have port: mcycle_type  in  3  `CYCLE_*` code (z80.vh) of the cycle starting, valid with mcycle_start.
REQ-006 SHALL have port: fetch_valid  in  1  opcode/operand byte fetched this T-state.
REQ-007 SHALL have port: fetch_byte  in  8  fetched byte, valid with fetch_valid.
REQ-008 SHALL have port: insn_end  in  1  last T-state of current instruction.
REQ-009 SHALL have port: z80fi_valid  out  1  one-cycle retire strobe.
REQ-010 SHALL have port: z80fi_insn  out  32  fetched bytes; byte n at [8n+7:8n], first fetched byte at [7:0].
REQ-011 SHALL have port: z80fi_insn_len  out  3  bytes captured, 0..4.
REQ-012 SHALL have port: z80fi_mcycle_types  out  18  slot k (mcycle k+1, k=0..5) at [3k+2:3k].
REQ-013 SHALL have port: z80fi_tcycles  out  24  slot k T-state count at [4k+3:4k].
REQ-014 SHALL have port: capture_error  out  1  protocol/overflow flag for the published instruction.

Function
REQ-015 SHALL implement states IDLE and ACTIVE; IDLE ignores all inputs except insn_start.
REQ-016 SHALL, on insn_start in IDLE, clear working buffers, open slot 0 with mcycle_type and count 1, go ACTIVE.
REQ-017 SHALL, on mcycle_start in ACTIVE, open next slot with mcycle_type and count 1.
REQ-018 SHALL increment the open slot's count on every ACTIVE T-state without mcycle_start, including the insn_end T-state; count saturates at 15.
REQ-019 SHALL append fetch_byte at index len and increment len on fetch_valid in ACTIVE, including the insn_start and insn_end T-states.
REQ-020 SHALL, on insn_end in ACTIVE, apply that T-state's count/fetch/slot updates, then on the next clk publish all working buffers to outputs, pulse z80fi_valid for exactly one cycle, return to IDLE.
REQ-021 SHALL hold published outputs stable until the next publish; z80fi_valid is 0 otherwise.
REQ-022 SHALL report unused slots as CYCLE_NONE with count 0 and unused insn bytes as 0.
REQ-023 SHALL, on a 5th fetch_valid, drop the byte, hold len at 4, flag error.
REQ-024 SHALL, on a 7th mcycle_start, drop the slot, keep counting into nothing (slot 5 frozen), flag error.
REQ-025 SHALL, on insn_start in ACTIVE without insn_end, discard the current instruction (no publish), restart capture per REQ-016, flag error on the new instruction.
REQ-026 SHALL, on insn_start and insn_end in the same T-state in ACTIVE, finalize and publish current per REQ-020, ignore the insn_start, set capture_error on that publish.
REQ-027 SHALL, on insn_end in IDLE, ignore it.
REQ-028 SHALL update capture_error only at publish, reflecting any flag raised during that instruction.

Reset
REQ-029 SHALL, on reset assertion at any time including mid-capture, immediately force IDLE, z80fi_valid=0, z80fi_insn=0, z80fi_insn_len=0, all slot types CYCLE_NONE, all tcycles 0, capture_error=0, discarding partial capture.
REQ-030 SHALL require insn_start after reset release before any capture.

Verification
REQ-031 SHALL pass LD R,A: insn_start+M1 fetch ED (4 T), M1 fetch 4F (4 T), EXTENDED 1 T with insn_end -> next cycle valid=1, insn=0x00004FED, len=2, types M1,M1,EXTENDED,NONE,NONE,NONE, tcycles 4,4,1,0,0,0, error=0.
REQ-032 SHALL pass overflow: 5 fetches across 7 mcycles -> len=4, insn holds first 4 bytes, 6 slots filled, error=1.
REQ-033 SHALL pass saturation: single M1 slot lasting 20 T-states -> tcycles slot0=15.
REQ-034 SHALL pass reset mid-capture: reset after 2 T of M1 -> all outputs reset values, no valid; next clean NOP (00, 4 T) publishes insn=0, len=1, tcycles 4.
REQ-035 SHALL pass back-to-back: insn_end then insn_start next T-state -> two valid pulses, second instruction's buffers uncontaminated by first.
REQ-036 SHALL pass abandon: insn_start mid-instruction -> no publish for first, second publishes with error=1.
